mc_control_fsm: RTL and testbench

- Multi-cycle RV32I control unit, sitting on the opposite side of the ALU control interface.
- Sequences fetch/decode/execute/writeback, generates every datapath enable and mux select, and produces the 3-bit `alu_control` code the ALU consumes.
- Consumes the ALU `zero` flag to resolve branches.
- Stalls on a memory-ready handshake in memory-access states.

---
 rtl/mc_ctrl_pkg.sv | 66 ++++++
 rtl/alu_decoder.sv | 33 +++
 rtl/mc_control_fsm.sv | 153 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, ALU control codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BRANCH
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    // State-derived request to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

    // Immediate format implied by the opcode alone
    function automatic logic [1:0] imm_for_op(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request plus instruction funct fields to the 3-bit ALU op.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type, so addi never becomes sub
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences the datapath and drives all enables/selects.
// Define CTRL_BNE_EN to also resolve bne (funct3=001) in the BRANCH state.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
`ifdef CTRL_BNE_EN
            3'b001:  branch_taken = !zero;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        adr_src       = ADR_PC;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        imm_src       = imm_for_op(op);
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: ;
                    default: illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD:  adr_src = ADR_RESULT;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = ADR_RESULT;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pc_write  = branch_taken;
            end
            default: ;
        endcase
        // Reset leaves the selects at their FETCH values but must not fire any strobe
        if (!rst_n) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class state by state
// and compares the packed control outputs against hand-written expectations.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [14:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr)
    );

    assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_control, illegal_instr};

    function automatic logic [14:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Check the current state's outputs (and optionally imm_src), then advance one clock.
    task automatic expect_st(input string tag, input logic [14:0] e,
                             input logic chk_imm, input logic [1:0] imm_e);
        #1;
        check(tag, {17'd0, outs}, {17'd0, e});
        if (chk_imm) check({tag, "_imm"}, {30'd0, imm_src}, {30'd0, imm_e});
        @(posedge clk);
        #1;
    endtask

    logic [14:0] e_f1, e_f0, e_dec, e_ill, e_aluwb, e_ma, e_mr, e_mwb, e_mw, e_jal;

    // {funct3, funct7b5, expected alu_control}
    logic [6:0] r_tab [9];
    logic [6:0] i_tab [3];
    logic       bne_exp;

    initial begin
        e_f1    = pk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        e_f0    = pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        e_dec   = pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
        e_ill   = pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1);
        e_aluwb = pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        e_ma    = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        e_mr    = pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        e_mwb   = pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
        e_mw    = pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        e_jal   = pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);

        r_tab[0] = {3'b000, 1'b0, 3'b000};
        r_tab[1] = {3'b000, 1'b1, 3'b001};
        r_tab[2] = {3'b001, 1'b0, 3'b100};
        r_tab[3] = {3'b010, 1'b0, 3'b101};
        r_tab[4] = {3'b011, 1'b0, 3'b000};
        r_tab[5] = {3'b100, 1'b0, 3'b111};
        r_tab[6] = {3'b101, 1'b0, 3'b110};
        r_tab[7] = {3'b110, 1'b0, 3'b011};
        r_tab[8] = {3'b111, 1'b0, 3'b010};
        i_tab[0] = {3'b000, 1'b1, 3'b000};
        i_tab[1] = {3'b110, 1'b0, 3'b011};
        i_tab[2] = {3'b101, 1'b1, 3'b110};
`ifdef CTRL_BNE_EN
        bne_exp = 1'b1;
`else
        bne_exp = 1'b0;
`endif

        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outs", {17'd0, outs}, {17'd0, e_f0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type through every funct3 (and sub): 4 cycles each
        for (int i = 0; i < 9; i++) begin
            op = 7'b0110011; funct3 = r_tab[i][6:4]; funct7b5 = r_tab[i][3];
            expect_st("r_fetch", e_f1, 1'b0, 2'b00);
            expect_st("r_decode", e_dec, 1'b1, 2'b10);
            expect_st("r_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, r_tab[i][2:0], 0),
                      1'b0, 2'b00);
            expect_st("r_aluwb", e_aluwb, 1'b0, 2'b00);
            $display("rtype f3=%b f7b5=%b done", funct3, funct7b5);
        end

        // I-type: addi with bit30 set must stay add
        for (int i = 0; i < 3; i++) begin
            op = 7'b0010011; funct3 = i_tab[i][6:4]; funct7b5 = i_tab[i][3];
            expect_st("i_fetch", e_f1, 1'b0, 2'b00);
            expect_st("i_decode", e_dec, 1'b0, 2'b00);
            expect_st("i_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, i_tab[i][2:0], 0),
                      1'b1, 2'b00);
            expect_st("i_aluwb", e_aluwb, 1'b0, 2'b00);
            $display("itype f3=%b f7b5=%b done", funct3, funct7b5);
        end

        // lw with three wait cycles in MEMREAD; mem_ready low in DECODE is ignored
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        expect_st("lw_fetch", e_f1, 1'b0, 2'b00);
        mem_ready = 1'b0;
        expect_st("lw_decode", e_dec, 1'b0, 2'b00);
        expect_st("lw_memadr", e_ma, 1'b1, 2'b00);
        expect_st("lw_memread0", e_mr, 1'b0, 2'b00);
        expect_st("lw_memread1", e_mr, 1'b0, 2'b00);
        expect_st("lw_memread2", e_mr, 1'b0, 2'b00);
        mem_ready = 1'b1;
        expect_st("lw_memread3", e_mr, 1'b0, 2'b00);
        expect_st("lw_memwb", e_mwb, 1'b0, 2'b00);
        $display("lw with 3 wait states done");

        // FETCH stall, then sw with one wait in MEMWRITE
        op = 7'b0100011;
        mem_ready = 1'b0;
        expect_st("sw_fetch_stall", e_f0, 1'b0, 2'b00);
        mem_ready = 1'b1;
        expect_st("sw_fetch", e_f1, 1'b0, 2'b00);
        expect_st("sw_decode", e_dec, 1'b0, 2'b00);
        expect_st("sw_memadr", e_ma, 1'b1, 2'b01);
        mem_ready = 1'b0;
        expect_st("sw_memwrite0", e_mw, 1'b0, 2'b00);
        mem_ready = 1'b1;
        expect_st("sw_memwrite1", e_mw, 1'b0, 2'b00);
        $display("sw with fetch stall and 1 wait state done");

        // beq taken / not taken, then bne with zero=0 and zero=1
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        expect_st("beq1_fetch", e_f1, 1'b0, 2'b00);
        expect_st("beq1_decode", e_dec, 1'b0, 2'b00);
        expect_st("beq1_branch", pk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0), 1'b0, 2'b00);
        zero = 1'b0;
        expect_st("beq0_fetch", e_f1, 1'b0, 2'b00);
        expect_st("beq0_decode", e_dec, 1'b0, 2'b00);
        expect_st("beq0_branch", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0), 1'b0, 2'b00);
        funct3 = 3'b001;
        expect_st("bne0_fetch", e_f1, 1'b0, 2'b00);
        expect_st("bne0_decode", e_dec, 1'b0, 2'b00);
        expect_st("bne0_branch", pk(bne_exp, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0),
                  1'b0, 2'b00);
        zero = 1'b1;
        expect_st("bne1_fetch", e_f1, 1'b0, 2'b00);
        expect_st("bne1_decode", e_dec, 1'b0, 2'b00);
        expect_st("bne1_branch", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0), 1'b0, 2'b00);
        $display("branches done");

        // jal
        op = 7'b1101111; funct3 = 3'b000;
        expect_st("jal_fetch", e_f1, 1'b0, 2'b00);
        expect_st("jal_decode", e_dec, 1'b0, 2'b00);
        expect_st("jal_jal", e_jal, 1'b0, 2'b00);
        expect_st("jal_aluwb", e_aluwb, 1'b0, 2'b00);
        $display("jal done");

        // illegal opcode: pulse in DECODE, straight back to FETCH
        op = 7'b0000000;
        expect_st("ill_fetch", e_f1, 1'b0, 2'b00);
        expect_st("ill_decode", e_ill, 1'b0, 2'b00);
        op = 7'b0100011;
        expect_st("ill_refetch", e_f1, 1'b0, 2'b00);
        $display("illegal opcode done");

        // reset mid-store: strobes drop immediately, restart at FETCH
        expect_st("rst_decode", e_dec, 1'b0, 2'b00);
        expect_st("rst_memadr", e_ma, 1'b0, 2'b00);
        mem_ready = 1'b0;
        #1;
        check("rst_memwrite", {17'd0, outs}, {17'd0, e_mw});
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {17'd0, outs}, {17'd0, e_f0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        expect_st("rst_restart_fetch", e_f1, 1'b0, 2'b00);
        expect_st("rst_restart_decode", e_dec, 1'b0, 2'b00);
        $display("reset mid-instruction done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
